// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line input and received-byte status bundle for
//                uart_rx. The receiver uses the master view, a consumer the
//                slave view.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    input  rx,
    output data_out, data_valid, frame_err, parity_err, busy
  );

  modport slave (
    output rx,
    input  data_out, data_valid, frame_err, parity_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 8N1 by default. Defining UART_RX_PARITY_EN
//                adds an even parity bit between the data and stop bits.
//                A single baud down-counter times every bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_rx_if.master bus
);

  localparam int              CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_reload;
  logic          cnt_zero;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          shift_en;
  logic          frame_ok;
  logic          frame_bad;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad;
  logic          parity_en;
  logic          parity_fail;
  logic          perr_q;
`endif

  assign cnt_zero = (cnt == '0);

  // Two-flop synchronizer; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and one-shot frame strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_en   = 1'b0;
    parity_fail = 1'b0;
`endif
    case (state)
      IDLE:      if (!rxs) state_next = START;
      START:     if (cnt_zero) state_next = rxs ? IDLE : DATA;
      DATA: begin
        if (cnt_zero) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          parity_en  = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_zero) begin
          // A bad stop bit outranks a parity mismatch.
          if (!rxs) begin
            frame_bad  = 1'b1;
            state_next = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (parity_bad) begin
            parity_fail = 1'b1;
            state_next  = IDLE;
          end
`endif
          else begin
            frame_ok   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_HIGH: if (rxs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Reload value for the baud counter, chosen by the state being entered.
  always_comb begin
    cnt_reload = '0;
    case (state_next)
      START:   cnt_reload = HALF_RELOAD;
      DATA:    cnt_reload = FULL_RELOAD;
`ifdef UART_RX_PARITY_EN
      PARITY:  cnt_reload = FULL_RELOAD;
`endif
      STOP:    cnt_reload = FULL_RELOAD;
      default: cnt_reload = '0;
    endcase
  end

  // Baud counter: reload on any state change or expiry, else count down.
  always_ff @(posedge clk) begin
    if (rst)                                    cnt <= '0;
    else if (cnt_zero || (state_next != state)) cnt <= cnt_reload;
    else                                        cnt <= cnt - CW'(1);
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if (state == IDLE && !rxs) begin
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= {rxs, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the received bit must equal the XOR of the data bits.
  always_ff @(posedge clk) begin
    if (rst)            parity_bad <= 1'b0;
    else if (parity_en) parity_bad <= rxs ^ (^shift);
  end
`endif

  // Registered outputs: pulses and data_out appear the cycle after STOP samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= frame_ok;
      ferr_q  <= frame_bad;
`ifdef UART_RX_PARITY_EN
      perr_q  <= parity_fail;
`endif
      if (frame_ok) data_q <= shift;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy       = (state != IDLE);

endmodule
`default_nettype wire
